// File: rtl/mul_rs.sv
// Reservation station feeding the pipelined multiplier: holds issued multiplies,
// snoops the CDB for pending operand tags and dispatches one complete entry per cycle.
module mul_rs #(
  parameter int unsigned ENTRIES    = 3,
  parameter logic [3:0]  LABEL_BASE = 4'd4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [3:0]  issue_q1,
  input  logic [31:0] issue_v1,
  input  logic [3:0]  issue_q2,
  input  logic [31:0] issue_v2,
  output logic [3:0]  issue_label,
  input  logic        cdb_valid,
  input  logic [3:0]  cdb_label,
  input  logic [31:0] cdb_data,
  input  logic        fu_available,
  output logic        fu_wen,
  output logic [31:0] fu_data1,
  output logic [31:0] fu_data2,
  output logic [3:0]  fu_label
);

  logic        busy [ENTRIES];
  logic [3:0]  q1   [ENTRIES];
  logic [31:0] v1   [ENTRIES];
  logic [3:0]  q2   [ENTRIES];
  logic [31:0] v2   [ENTRIES];

  logic [3:0]  alloc_idx;
  logic [3:0]  sel;
  logic        any_rdy;
  logic        accept;
  logic        byp1;
  logic        byp2;

  always_comb begin
    issue_ready = 1'b0;
    alloc_idx   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!issue_ready && !busy[i]) begin
        issue_ready = 1'b1;
        alloc_idx   = 4'(i);
      end
    end
  end

  assign issue_label = LABEL_BASE + alloc_idx;
  assign accept      = issue_valid && issue_ready;
  assign byp1        = cdb_valid && (issue_q1 != '0) && (cdb_label == issue_q1);
  assign byp2        = cdb_valid && (issue_q2 != '0) && (cdb_label == issue_q2);

  // Operand muxing is folded into the priority scan so no variable array index is needed.
  always_comb begin
    any_rdy  = 1'b0;
    sel      = '0;
    fu_data1 = '0;
    fu_data2 = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!any_rdy && busy[i] && (q1[i] == '0) && (q2[i] == '0)) begin
        any_rdy  = 1'b1;
        sel      = 4'(i);
        fu_data1 = v1[i];
        fu_data2 = v2[i];
      end
    end
  end

  assign fu_wen   = any_rdy && fu_available;
  assign fu_label = any_rdy ? (LABEL_BASE + sel) : '0;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        busy[i] <= 1'b0;
        q1[i]   <= '0;
        v1[i]   <= '0;
        q2[i]   <= '0;
        v2[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (fu_wen && (sel == 4'(i)))
          busy[i] <= 1'b0;
        if (busy[i] && (q1[i] != '0) && cdb_valid && (cdb_label == q1[i])) begin
          v1[i] <= cdb_data;
          q1[i] <= '0;
        end
        if (busy[i] && (q2[i] != '0) && cdb_valid && (cdb_label == q2[i])) begin
          v2[i] <= cdb_data;
          q2[i] <= '0;
        end
        // Allocation only ever targets a free entry, so it never collides with snoop/dispatch.
        if (accept && (alloc_idx == 4'(i))) begin
          busy[i] <= 1'b1;
          q1[i]   <= byp1 ? '0 : issue_q1;
          v1[i]   <= byp1 ? cdb_data : issue_v1;
          q2[i]   <= byp2 ? '0 : issue_q2;
          v2[i]   <= byp2 ? cdb_data : issue_v2;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_rs.sv
// Self-checking bench for mul_rs: directed scenarios plus random traffic compared
// against an entry-list reference model.
module tb_mul_rs;

  logic        clk = 1'b0;
  logic        nRST;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_q1;
  logic [31:0] issue_v1;
  logic [3:0]  issue_q2;
  logic [31:0] issue_v2;
  logic [3:0]  issue_label;
  logic        cdb_valid;
  logic [3:0]  cdb_label;
  logic [31:0] cdb_data;
  logic        fu_available;
  logic        fu_wen;
  logic [31:0] fu_data1;
  logic [31:0] fu_data2;
  logic [3:0]  fu_label;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_rs #(.ENTRIES(3), .LABEL_BASE(4'd4)) dut (
    .clk(clk), .nRST(nRST),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_q1(issue_q1), .issue_v1(issue_v1),
    .issue_q2(issue_q2), .issue_v2(issue_v2),
    .issue_label(issue_label),
    .cdb_valid(cdb_valid), .cdb_label(cdb_label), .cdb_data(cdb_data),
    .fu_available(fu_available), .fu_wen(fu_wen),
    .fu_data1(fu_data1), .fu_data2(fu_data2), .fu_label(fu_label)
  );

  // Reference model: an entry is waiting on a tag until the CDB delivers that value.
  typedef struct {
    bit        busy;
    bit [3:0]  t1, t2;
    bit [31:0] d1, d2;
  } ent_t;
  ent_t m [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int first_free();
    for (int i = 0; i < 3; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int first_ready();
    for (int i = 0; i < 3; i++) if (m[i].busy && m[i].t1 == 0 && m[i].t2 == 0) return i;
    return -1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0};
  endfunction

  // Drive one cycle, compare every output with the model, then advance the model.
  task automatic cyc(input bit iv, input bit [3:0] a1, input bit [31:0] b1,
                     input bit [3:0] a2, input bit [31:0] b2,
                     input bit cv, input bit [3:0] cl, input bit [31:0] cd, input bit fa);
    int ff, fr;
    bit wen;
    @(negedge clk);
    issue_valid = iv; issue_q1 = a1; issue_v1 = b1; issue_q2 = a2; issue_v2 = b2;
    cdb_valid = cv; cdb_label = cl; cdb_data = cd; fu_available = fa;
    #1;
    ff  = first_free();
    fr  = first_ready();
    wen = (fr >= 0) && fa;
    chk("issue_ready", issue_ready, (ff >= 0));
    if (ff >= 0) chk("issue_label", issue_label, 4 + ff);
    chk("fu_wen", fu_wen, wen);
    chk("fu_data1", fu_data1, (fr >= 0) ? m[fr].d1 : 0);
    chk("fu_data2", fu_data2, (fr >= 0) ? m[fr].d2 : 0);
    chk("fu_label", fu_label, (fr >= 0) ? 4 + fr : 0);
    for (int i = 0; i < 3; i++) begin
      if (m[i].busy && cv && cl != 0) begin
        if (m[i].t1 == cl) begin m[i].t1 = 0; m[i].d1 = cd; end
        if (m[i].t2 == cl) begin m[i].t2 = 0; m[i].d2 = cd; end
      end
    end
    if (wen) m[fr].busy = 0;
    if (iv && ff >= 0) begin
      m[ff].busy = 1;
      m[ff].t1 = a1; m[ff].d1 = b1;
      m[ff].t2 = a2; m[ff].d2 = b2;
      if (cv && a1 != 0 && cl == a1) begin m[ff].t1 = 0; m[ff].d1 = cd; end
      if (cv && a2 != 0 && cl == a2) begin m[ff].t2 = 0; m[ff].d2 = cd; end
    end
  endtask

  task automatic idle(input bit fa);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, fa);
  endtask

  // Asynchronous reset dropped mid-cycle, with whatever inputs are currently applied.
  task automatic reset_mid();
    @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    chk("rst_ready", issue_ready, 1);
    chk("rst_wen", fu_wen, 0);
    chk("rst_data1", fu_data1, 0);
    chk("rst_data2", fu_data2, 0);
    chk("rst_label", fu_label, 0);
    model_clear();
    @(negedge clk);
    issue_valid = 0; cdb_valid = 0; fu_available = 0;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    issue_valid = 0; issue_q1 = 0; issue_v1 = 0; issue_q2 = 0; issue_v2 = 0;
    cdb_valid = 0; cdb_label = 0; cdb_data = 0; fu_available = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", issue_ready, 1);
    chk("reset_wen", fu_wen, 0);
    chk("reset_data1", fu_data1, 0);
    chk("reset_data2", fu_data2, 0);
    chk("reset_label", fu_label, 0);
    @(negedge clk);
    nRST = 1'b1;

    // Complete operands dispatch one cycle after accept.
    cyc(1, 0, 3, 0, 5, 0, 0, 0, 1);
    chk("t2_label", issue_label, 4);
    idle(1);
    chk("t2_wen", fu_wen, 1);
    chk("t2_d1", fu_data1, 3);
    chk("t2_d2", fu_data2, 5);
    chk("t2_lab", fu_label, 4);
    idle(1);
    chk("t2_wen_off", fu_wen, 0);
    chk("t2_free", issue_label, 4);

    // Operand resolved by CDB becomes dispatchable the next cycle.
    cyc(1, 2, 0, 0, 7, 0, 0, 0, 1);
    idle(1);
    chk("t3_wait1", fu_wen, 0);
    cyc(0, 0, 0, 0, 0, 1, 2, 6, 1);
    chk("t3_wait2", fu_wen, 0);
    idle(1);
    chk("t3_wen", fu_wen, 1);
    chk("t3_d1", fu_data1, 6);
    chk("t3_d2", fu_data2, 7);
    chk("t3_lab", fu_label, 4);

    // Same-cycle bypass on accept.
    cyc(1, 2, 0, 0, 1, 1, 2, 9, 1);
    chk("t4_label", issue_label, 4);
    idle(1);
    chk("t4_wen", fu_wen, 1);
    chk("t4_d1", fu_data1, 9);

    // Fill the station while the multiplier is stalled.
    idle(0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 2, 0, 0, 10 + k, 0, 0, 0, 0);
      chk("t5_label", issue_label, 4 + k);
    end
    cyc(1, 0, 11, 0, 22, 0, 0, 0, 0);
    chk("t5_full", issue_ready, 0);
    cyc(0, 0, 0, 0, 0, 1, 2, 1, 0);
    chk("t5_hold", fu_wen, 0);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      chk("t5_wen", fu_wen, 1);
      chk("t5_lab", fu_label, 4 + k);
      if (k == 1) chk("t5_ready_back", issue_ready, 1);
    end
    idle(1);
    chk("t5_empty", fu_wen, 0);

    // Reset while two entries wait on a tag that is being broadcast.
    cyc(1, 3, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 2, 0, 0, 0, 0);
    issue_valid = 0; cdb_valid = 1; cdb_label = 3; cdb_data = 32'h55;
    reset_mid();
    cyc(0, 0, 0, 0, 0, 1, 3, 32'h77, 1);
    idle(1);
    chk("t6_no_dispatch", fu_wen, 0);
    chk("t6_ready", issue_ready, 1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset_mid();
      end else begin
        cyc($urandom_range(0, 1),
            ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 3)) : 4'd0, $urandom(),
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 3)) : 4'd0, $urandom(),
            $urandom_range(0, 1), 4'($urandom_range(0, 3)), $urandom(),
            $urandom_range(0, 3) != 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
